// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
//
// Purpose: groups the operand (input) and result (output) valid/ready channels.
// Ports (signals):
//   in_valid, in_ready, a, b, bin       operand channel, master -> slave
//   out_valid, out_ready, diff, bout    result channel, slave -> master
//   busy                                slave status, high while computing
// Modports: master drives operands and consumes results; slave is the subtractor.

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with valid/ready handshakes
//
// Purpose: computes diff = a - b - bin (mod 2^WIDTH) and bout = (a < b + bin),
// one full-subtract step per clock, borrow held in a register between bits.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   sub_if   serial_subtractor_if.slave: operand channel (in_valid/in_ready/a/b/bin),
//            result channel (out_valid/out_ready/diff/bout), busy status

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   sub_if
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_sh_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             bit_d;
    logic             brw_d;
    logic [WIDTH-1:0] diff_sh_d;
    logic             in_ready;
    logic             accept;

    // One full-subtract step: two half-subtractors plus an OR for the borrow.
    always_comb begin
        bit_d     = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        brw_d     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        diff_sh_d = {bit_d, diff_sh_q[WIDTH-1:1]};
    end

    // Ready in DONE only when the pending result leaves this same cycle,
    // which is what allows back-to-back operations.
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & sub_if.out_ready);
    assign accept   = in_ready & sub_if.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_sh_q   <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh_q    <= sub_if.a;
                        b_sh_q    <= sub_if.b;
                        brw_q     <= sub_if.bin;
                        diff_sh_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    diff_sh_q <= diff_sh_d;
                    brw_q     <= brw_d;
                    cnt_q     <= cnt_q + 1'b1;
                    // Processing the MSB: publish the completed result directly
                    // from the step logic so it lands on the WIDTH-th edge.
                    if (cnt_q == LAST_BIT) begin
                        diff_q      <= diff_sh_d;
                        bout_q      <= brw_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (sub_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (sub_if.in_valid) begin
                            a_sh_q    <= sub_if.a;
                            b_sh_q    <= sub_if.b;
                            brw_q     <= sub_if.bin;
                            diff_sh_q <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sub_if.in_ready  = in_ready;
    assign sub_if.out_valid = out_valid_q;
    assign sub_if.diff      = diff_q;
    assign sub_if.bout      = bout_q;
    assign sub_if.busy      = busy_q;

endmodule
